rob_alloc_queue: RTL and testbench

//  Reorder-buffer responder end of the renaming->ROB allocation path. Accepts up to MACHINE_WIDTH
//  in-order allocations per cycle (exception, pcplus8, dst) and returns rob_addr_new per lane.

---
 rtl/rob_alloc_queue.sv | 171 +++++++++++++++++
 tb/tb_rob_alloc_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_queue.sv
// rob_alloc_queue
//   Reorder-buffer end of the rename->ROB allocation path. Hands out up to
//   MACHINE_WIDTH entries per cycle in program order. Records out-of-order
//   completions. Retires in order, up to MACHINE_WIDTH per cycle. Raises a
//   precise exception from the head entry and then flushes itself.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   alloc_*         per-lane allocation request (valid, dst, pc+8, exception)
//   alloc_ready     room for MACHINE_WIDTH entries and no exception pending
//   rob_addr_new    entry index assigned to each lane (combinational)
//   cmp_*           completion write ports (valid, entry address, result)
//   retire_*        in-order retire slots (valid, dst, result)
//   exc_valid/code/pc  head exception pulse, its code, and its pc (pc+8 - 8)
//   stall_cnt       only with ROB_STALL_CNT_EN: cycles a request was refused
//
// Build option
//   ROB_STALL_CNT_EN  adds the saturating stall_cnt output.
module rob_alloc_queue #(
  parameter int MACHINE_WIDTH = 2,
  parameter int ROB_DEPTH     = 16,
  parameter int CMP_PORTS     = 2,
  parameter int EXC_W         = 8,
  localparam int AW           = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [MACHINE_WIDTH-1:0]       alloc_valid,
  input  logic [MACHINE_WIDTH*5-1:0]     alloc_dst,
  input  logic [MACHINE_WIDTH*32-1:0]    alloc_pcplus8,
  input  logic [MACHINE_WIDTH*EXC_W-1:0] alloc_exc,
  output logic                           alloc_ready,
  output logic [MACHINE_WIDTH*AW-1:0]    rob_addr_new,
  input  logic [CMP_PORTS-1:0]           cmp_valid,
  input  logic [CMP_PORTS*AW-1:0]        cmp_addr,
  input  logic [CMP_PORTS*32-1:0]        cmp_data,
  output logic [MACHINE_WIDTH-1:0]       retire_valid,
  output logic [MACHINE_WIDTH*5-1:0]     retire_dst,
  output logic [MACHINE_WIDTH*32-1:0]    retire_data,
  output logic                           exc_valid,
  output logic [EXC_W-1:0]               exc_code,
  output logic [31:0]                    exc_pc
`ifdef ROB_STALL_CNT_EN
  ,
  output logic [31:0]                    stall_cnt
`endif
);

  localparam int PW = AW + 1;

  // Control state (reset)
  logic [PW-1:0]        r_head, r_tail;
  logic [ROB_DEPTH-1:0] r_busy, r_done;

  // Entry payload (not reset; only read behind busy)
  logic [4:0]       r_dst  [ROB_DEPTH];
  logic [31:0]      r_pc   [ROB_DEPTH];
  logic [EXC_W-1:0] r_exc  [ROB_DEPTH];
  logic [31:0]      r_data [ROB_DEPTH];

  logic [AW-1:0]            w_head_idx;
  logic [PW-1:0]            w_count, w_free, w_alloc_cnt, w_ret_cnt;
  logic                     w_exc_head, w_chain;
  logic [MACHINE_WIDTH-1:0] w_ret;

  assign w_head_idx = r_head[AW-1:0];
  assign w_count    = r_tail - r_head;
  assign w_free     = PW'(ROB_DEPTH) - w_count;
  assign w_exc_head = r_busy[w_head_idx] && (r_exc[w_head_idx] != '0);

  assign exc_valid   = !reset && w_exc_head;
  assign exc_code    = exc_valid ? r_exc[w_head_idx] : '0;
  assign exc_pc      = exc_valid ? (r_pc[w_head_idx] - 32'd8) : '0;
  assign alloc_ready = !reset && !w_exc_head && (w_free >= PW'(MACHINE_WIDTH));

  // Lane i gets tail plus the number of valid lanes below it, so holes in
  // alloc_valid do not leave holes in the ROB.
  always_comb begin
    w_alloc_cnt  = '0;
    rob_addr_new = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      rob_addr_new[i*AW +: AW] = r_tail[AW-1:0] + w_alloc_cnt[AW-1:0];
      if (alloc_valid[i]) w_alloc_cnt = w_alloc_cnt + PW'(1);
    end
  end

  // Retire chain: a slot retires only if every older slot does. An entry
  // carrying an exception breaks the chain, so it can only leave via the
  // exception flush once it is at the head.
  always_comb begin
    w_ret       = '0;
    w_ret_cnt   = '0;
    retire_dst  = '0;
    retire_data = '0;
    w_chain     = !reset;
    for (int k = 0; k < MACHINE_WIDTH; k++) begin
      w_chain = w_chain && r_busy[w_head_idx + AW'(k)] && r_done[w_head_idx + AW'(k)] &&
                (r_exc[w_head_idx + AW'(k)] == '0);
      w_ret[k] = w_chain;
      if (w_chain) begin
        retire_dst[k*5 +: 5]   = r_dst[w_head_idx + AW'(k)];
        retire_data[k*32 +: 32] = r_data[w_head_idx + AW'(k)];
        w_ret_cnt = w_ret_cnt + PW'(1);
      end
    end
  end
  assign retire_valid = w_ret;

  // Control update. Retire clears come after completions so a late duplicate
  // completion cannot resurrect a retiring entry; allocations only target
  // free entries, so they never collide with either.
  always_ff @(posedge clk) begin
    if (reset || w_exc_head) begin
      r_head <= '0;
      r_tail <= '0;
      r_busy <= '0;
      r_done <= '0;
    end else begin
      for (int c = 0; c < CMP_PORTS; c++) begin
        if (cmp_valid[c] && r_busy[cmp_addr[c*AW +: AW]]) r_done[cmp_addr[c*AW +: AW]] <= 1'b1;
      end
      for (int k = 0; k < MACHINE_WIDTH; k++) begin
        if (w_ret[k]) begin
          r_busy[w_head_idx + AW'(k)] <= 1'b0;
          r_done[w_head_idx + AW'(k)] <= 1'b0;
        end
      end
      if (alloc_ready) begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
          if (alloc_valid[i]) begin
            r_busy[rob_addr_new[i*AW +: AW]] <= 1'b1;
            r_done[rob_addr_new[i*AW +: AW]] <= (alloc_exc[i*EXC_W +: EXC_W] != '0);
          end
        end
        r_tail <= r_tail + w_alloc_cnt;
      end
      r_head <= r_head + w_ret_cnt;
    end
  end

  // Payload writes; stray writes to free entries are harmless.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CMP_PORTS; c++) begin
      if (cmp_valid[c] && r_busy[cmp_addr[c*AW +: AW]]) r_data[cmp_addr[c*AW +: AW]] <= cmp_data[c*32 +: 32];
    end
    if (alloc_ready) begin
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (alloc_valid[i]) begin
          r_dst[rob_addr_new[i*AW +: AW]] <= alloc_dst[i*5 +: 5];
          r_pc[rob_addr_new[i*AW +: AW]]  <= alloc_pcplus8[i*32 +: 32];
          r_exc[rob_addr_new[i*AW +: AW]] <= alloc_exc[i*EXC_W +: EXC_W];
        end
      end
    end
  end

`ifdef ROB_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Survives exception flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((|alloc_valid) && !alloc_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rob_alloc_queue.sv
module tb_rob_alloc_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  alloc_valid;
  logic [9:0]  alloc_dst;
  logic [63:0] alloc_pcplus8;
  logic [15:0] alloc_exc;
  logic        alloc_ready;
  logic [7:0]  rob_addr_new;
  logic [1:0]  cmp_valid;
  logic [7:0]  cmp_addr;
  logic [63:0] cmp_data;
  logic [1:0]  retire_valid;
  logic [9:0]  retire_dst;
  logic [63:0] retire_data;
  logic        exc_valid;
  logic [7:0]  exc_code;
  logic [31:0] exc_pc;

  int n_chk  = 0;
  int n_fail = 0;

  rob_alloc_queue #(.MACHINE_WIDTH(2), .ROB_DEPTH(16), .CMP_PORTS(2), .EXC_W(8)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_pcplus8(alloc_pcplus8),
    .alloc_exc(alloc_exc), .alloc_ready(alloc_ready), .rob_addr_new(rob_addr_new),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_data(cmp_data),
    .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_data(retire_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst;
    logic [1:0]  av;
    logic [4:0]  d0, d1;
    logic [31:0] p0;
    logic [7:0]  x0;
    logic [1:0]  cv;
    logic [3:0]  ca0;
    logic [31:0] cd0;
    logic        e_rdy;
    logic [3:0]  e_a0, e_a1;
    logic [1:0]  e_rv;
    logic [4:0]  e_rd0, e_rd1;
    logic [31:0] e_dt0, e_dt1;
    logic        e_exc;
    logic [7:0]  e_code;
    logic [31:0] e_epc;
  } vec_t;

  function automatic vec_t mk(
    input logic [31:0] rst, av, d0, d1, p0, x0, cv, ca0, cd0,
    input logic [31:0] rdy, a0, a1, rv, rd0, rd1, dt0, dt1, ex, code, epc);
    vec_t v;
    v.rst = rst[0];     v.av = av[1:0];     v.d0 = d0[4:0];     v.d1 = d1[4:0];
    v.p0 = p0;          v.x0 = x0[7:0];     v.cv = cv[1:0];     v.ca0 = ca0[3:0];
    v.cd0 = cd0;        v.e_rdy = rdy[0];   v.e_a0 = a0[3:0];   v.e_a1 = a1[3:0];
    v.e_rv = rv[1:0];   v.e_rd0 = rd0[4:0]; v.e_rd1 = rd1[4:0]; v.e_dt0 = dt0;
    v.e_dt1 = dt1;      v.e_exc = ex[0];    v.e_code = code[7:0]; v.e_epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; alloc_valid = '0; alloc_dst = '0; alloc_pcplus8 = '0;
    alloc_exc = '0; cmp_valid = '0; cmp_addr = '0; cmp_data = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  vec_t vecs[14];

  initial begin
    // rows: rst av d0 d1 p0 x0 cv ca0 cd0 | rdy a0 a1 rv rd0 rd1 dt0 dt1 exc code epc
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 3, 3, 4, 32'h100, 0, 0, 0, 0,           1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hAAAA0001,      1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 32'hAAAA0000,      1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                  1, 2, 2, 3, 3, 4, 32'hAAAA0000, 32'hAAAA0001, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 5, 0, 32'hBFC00108, 8'h0A, 0, 0, 0,  1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 6, 0, 0, 0, 1, 2, 32'h12345678,
                  0, 3, 4, 0, 0, 0, 0, 0, 1, 8'h0A, 32'hBFC00100);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 3, 7, 8, 32'h200, 0, 0, 0, 0,           1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 3, 9, 10, 32'h208, 0, 0, 0, 0,          1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 3, 11, 12, 32'h210, 0, 1, 0, 32'h55,    1, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    idle();
    reset = 1'b1;
    @(posedge clk); #1;

    // Table: basic alloc/complete/retire, head exception, reset with busy entries
    for (int i = 0; i < 14; i++) begin
      idle();
      reset         = vecs[i].rst;
      alloc_valid   = vecs[i].av;
      alloc_dst     = {vecs[i].d1, vecs[i].d0};
      alloc_pcplus8 = {vecs[i].p0 + 32'd4, vecs[i].p0};
      alloc_exc     = {8'h00, vecs[i].x0};
      cmp_valid     = vecs[i].cv;
      cmp_addr      = {4'h0, vecs[i].ca0};
      cmp_data      = {32'h0, vecs[i].cd0};
      @(negedge clk);
      chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].e_rdy));
      if (!vecs[i].rst) begin
        chk($sformatf("v%0d addr0", i), 32'(rob_addr_new[3:0]), 32'(vecs[i].e_a0));
        chk($sformatf("v%0d addr1", i), 32'(rob_addr_new[7:4]), 32'(vecs[i].e_a1));
      end
      chk($sformatf("v%0d retire_valid", i), 32'(retire_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv[0]) begin
        chk($sformatf("v%0d rdst0", i), 32'(retire_dst[4:0]), 32'(vecs[i].e_rd0));
        chk($sformatf("v%0d rdata0", i), retire_data[31:0], vecs[i].e_dt0);
      end
      if (vecs[i].e_rv[1]) begin
        chk($sformatf("v%0d rdst1", i), 32'(retire_dst[9:5]), 32'(vecs[i].e_rd1));
        chk($sformatf("v%0d rdata1", i), retire_data[63:32], vecs[i].e_dt1);
      end
      chk($sformatf("v%0d exc_valid", i), 32'(exc_valid), 32'(vecs[i].e_exc));
      if (vecs[i].e_exc || vecs[i].rst) begin
        chk($sformatf("v%0d exc_code", i), 32'(exc_code), 32'(vecs[i].e_code));
        chk($sformatf("v%0d exc_pc", i), exc_pc, vecs[i].e_epc);
      end
      @(posedge clk); #1;
    end
    idle();

    // Fill to 16 entries, then free the two head entries
    for (int c = 0; c < 8; c++) begin
      alloc_valid = 2'b11; alloc_dst = {5'd2, 5'd1};
      @(negedge clk);
      chk($sformatf("fill%0d ready", c), 32'(alloc_ready), 32'd1);
      chk($sformatf("fill%0d addr0", c), 32'(rob_addr_new[3:0]), 32'(2 * c));
      tick();
    end
    alloc_valid = 2'b11;
    @(negedge clk);
    chk("full ready", 32'(alloc_ready), 32'd0);
    chk("full addr0", 32'(rob_addr_new[3:0]), 32'd0);
    tick();
    cmp_valid = 2'b11; cmp_addr = {4'd1, 4'd0}; cmp_data = {32'h11, 32'h10};
    @(negedge clk);
    chk("full cmp ready", 32'(alloc_ready), 32'd0);
    chk("full cmp rv", 32'(retire_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("full retire rv", 32'(retire_valid), 32'd3);
    chk("full retire ready", 32'(alloc_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("after retire ready", 32'(alloc_ready), 32'd1);
    chk("after retire addr0", 32'(rob_addr_new[3:0]), 32'd0);
    tick();

    // count=14: retire 2 and allocate 2 in the same cycle
    cmp_valid = 2'b11; cmp_addr = {4'd3, 4'd2}; cmp_data = {32'h33, 32'h22};
    @(negedge clk);
    chk("c14 cmp rv", 32'(retire_valid), 32'd0);
    tick();
    alloc_valid = 2'b11; alloc_dst = {5'd6, 5'd5};
    @(negedge clk);
    chk("c14 rv", 32'(retire_valid), 32'd3);
    chk("c14 rdata1", retire_data[63:32], 32'h33);
    chk("c14 ready", 32'(alloc_ready), 32'd1);
    chk("c14 addr1", 32'(rob_addr_new[7:4]), 32'd1);
    tick();
    cmp_valid = 2'b01; cmp_addr = {4'd0, 4'd2}; cmp_data = {32'h0, 32'hDEAD};
    @(negedge clk);
    chk("c14 kept ready", 32'(alloc_ready), 32'd1);
    chk("c14 kept addr0", 32'(rob_addr_new[3:0]), 32'd2);
    chk("freed cmp rv", 32'(retire_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("freed cmp rv later", 32'(retire_valid), 32'd0);
    tick();

    // Wrap: 20 entries in order, completions on swapped ports
    reset = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) begin
      alloc_valid = 2'b11;
      alloc_dst   = {5'(2 * n + 2), 5'(2 * n + 1)};
      @(negedge clk);
      chk($sformatf("wrap%0d ready", n), 32'(alloc_ready), 32'd1);
      chk($sformatf("wrap%0d addr0", n), 32'(rob_addr_new[3:0]), 32'((2 * n) % 16));
      chk($sformatf("wrap%0d addr1", n), 32'(rob_addr_new[7:4]), 32'((2 * n + 1) % 16));
      tick();
      cmp_valid = 2'b11;
      cmp_addr  = {4'((2 * n) % 16), 4'((2 * n + 1) % 16)};
      cmp_data  = {32'hD000_0000 + 32'(2 * n), 32'hD000_0000 + 32'(2 * n + 1)};
      @(negedge clk);
      chk($sformatf("wrap%0d early rv", n), 32'(retire_valid), 32'd0);
      tick();
      @(negedge clk);
      chk($sformatf("wrap%0d rv", n), 32'(retire_valid), 32'd3);
      chk($sformatf("wrap%0d rdst0", n), 32'(retire_dst[4:0]), 32'(2 * n + 1));
      chk($sformatf("wrap%0d rdst1", n), 32'(retire_dst[9:5]), 32'(2 * n + 2));
      chk($sformatf("wrap%0d rdata0", n), retire_data[31:0], 32'hD000_0000 + 32'(2 * n));
      chk($sformatf("wrap%0d rdata1", n), retire_data[63:32], 32'hD000_0000 + 32'(2 * n + 1));
      tick();
    end

    // Exception in slot 1 blocks it until it reaches the head
    alloc_valid = 2'b11; alloc_dst = {5'd10, 5'd9};
    alloc_pcplus8 = {32'h304, 32'h300}; alloc_exc = {8'h33, 8'h00};
    @(negedge clk);
    chk("xs1 addr0", 32'(rob_addr_new[3:0]), 32'd4);
    tick();
    cmp_valid = 2'b01; cmp_addr = {4'd0, 4'd4}; cmp_data = {32'h0, 32'h77};
    @(negedge clk);
    chk("xs1 early rv", 32'(retire_valid), 32'd0);
    chk("xs1 early exc", 32'(exc_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("xs1 rv", 32'(retire_valid), 32'd1);
    chk("xs1 rdst0", 32'(retire_dst[4:0]), 32'd9);
    chk("xs1 rdata0", retire_data[31:0], 32'h77);
    chk("xs1 exc not yet", 32'(exc_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("xs1 exc", 32'(exc_valid), 32'd1);
    chk("xs1 code", 32'(exc_code), 32'h33);
    chk("xs1 pc", exc_pc, 32'h2FC);
    chk("xs1 exc rv", 32'(retire_valid), 32'd0);
    chk("xs1 exc ready", 32'(alloc_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("xs1 flushed exc", 32'(exc_valid), 32'd0);
    chk("xs1 flushed ready", 32'(alloc_ready), 32'd1);
    chk("xs1 flushed addr0", 32'(rob_addr_new[3:0]), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
